// File: rtl/nn_img_pkg.sv
// Shared types and default widths for the image-buffer sequencer.
//   state_e         : controller state encoding (2 bits)
//   *_DEF           : default parameter values used by nn_img_bf_ctrl
package nn_img_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 10;
  localparam int unsigned K_WIDTH_DEF    = 4;
  localparam int unsigned PIX_PER_WORD   = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/nn_img_win_agen.sv
// Sliding-window read address generator.
//   i_clear  : return base/offset to 0 (has priority over i_step)
//   i_step   : one word was issued; advance offset, or wrap and move base by stride
//   i_len/i_k/i_stride : latched configuration
//   o_pending : a full window starting at base still fits in the image
//   o_last    : current offset is the final word of the window
//   o_addr    : base + offset
module nn_img_win_agen #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned K_WIDTH    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_step,
  input  logic [ADDR_WIDTH-1:0] i_len,
  input  logic [K_WIDTH-1:0]    i_k,
  input  logic [K_WIDTH-1:0]    i_stride,
  output logic                  o_pending,
  output logic                  o_last,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  // One extra bit so base+K and base+stride cannot wrap past the image end.
  localparam int unsigned BW = ADDR_WIDTH + 1;

  logic [BW-1:0]      base_q, base_d;
  logic [K_WIDTH-1:0] off_q, off_d;
  logic [BW-1:0]      win_end;

  assign win_end   = base_q + BW'(i_k);
  assign o_pending = (win_end <= BW'(i_len));
  assign o_last    = (off_q == (i_k - K_WIDTH'(1)));
  assign o_addr    = ADDR_WIDTH'(base_q + BW'(off_q));

  // Counter next-state.
  always_comb begin
    base_d = base_q;
    off_d  = off_q;
    if (i_clear) begin
      base_d = '0;
      off_d  = '0;
    end else if (i_step) begin
      if (o_last) begin
        off_d  = '0;
        base_d = base_q + BW'(i_stride);
      end else begin
        off_d  = off_q + K_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      base_q <= '0;
      off_q  <= '0;
    end else begin
      base_q <= base_d;
      off_q  <= off_d;
    end
  end

endmodule

// File: rtl/nn_img_bf_ctrl.sv
// Image buffer sequencer: loads LEN words from a valid/ready stream into the
// buffer, then replays them as windows of K words with the base moving by STRIDE.
//   i_start/i_abort/i_cfg_*           : control and configuration
//   i_ld_valid/i_ld_data/o_ld_ready   : load stream (ready is combinational)
//   o_bf_wr_* / o_bf_rd_* / i_bf_rd_data : buffer ports (combinational)
//   o_rd_valid/o_rd_data/o_rd_last/i_rd_ready : registered output stream
//   o_busy/o_done                     : status (registered)
module nn_img_bf_ctrl #(
  parameter int unsigned DATA_WIDTH       = nn_img_pkg::DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH       = nn_img_pkg::ADDR_WIDTH_DEF,
  parameter int unsigned TOTAL_DATA_WIDTH = DATA_WIDTH * nn_img_pkg::PIX_PER_WORD,
  parameter int unsigned K_WIDTH          = nn_img_pkg::K_WIDTH_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic [ADDR_WIDTH-1:0]       i_cfg_len,
  input  logic [K_WIDTH-1:0]          i_cfg_k,
  input  logic [K_WIDTH-1:0]          i_cfg_stride,
  input  logic                        i_ld_valid,
  input  logic [TOTAL_DATA_WIDTH-1:0] i_ld_data,
  output logic                        o_ld_ready,
  output logic                        o_bf_wr_en,
  output logic [ADDR_WIDTH-1:0]       o_bf_wr_addr,
  output logic [TOTAL_DATA_WIDTH-1:0] o_bf_wr_data,
  output logic                        o_bf_rd_en,
  output logic [ADDR_WIDTH-1:0]       o_bf_rd_addr,
  input  logic [TOTAL_DATA_WIDTH-1:0] i_bf_rd_data,
  output logic                        o_rd_valid,
  output logic [TOTAL_DATA_WIDTH-1:0] o_rd_data,
  output logic                        o_rd_last,
  input  logic                        i_rd_ready,
  output logic                        o_busy,
  output logic                        o_done
);

  import nn_img_pkg::*;

  state_e                        state_q, state_d;
  logic [ADDR_WIDTH-1:0]         len_q, len_d;
  logic [K_WIDTH-1:0]            k_q, k_d;
  logic [K_WIDTH-1:0]            stride_q, stride_d;
  logic [ADDR_WIDTH-1:0]         ld_cnt_q, ld_cnt_d;
  logic                          rd_valid_q, rd_valid_d;
  logic [TOTAL_DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                          rd_last_q, rd_last_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic                          ld_fire;
  logic                          issue;
  logic                          win_pending;
  logic                          win_last;
  logic [ADDR_WIDTH-1:0]         win_addr;
  logic                          cfg_bad;

  assign o_ld_ready   = (state_q == ST_LOAD);
  assign ld_fire      = o_ld_ready && i_ld_valid;
  assign o_bf_wr_en   = ld_fire;
  assign o_bf_wr_addr = ld_cnt_q;
  assign o_bf_wr_data = i_ld_data;

  // A row is read whenever the output register is free or being drained.
  assign issue        = (state_q == ST_READ) && win_pending && (!rd_valid_q || i_rd_ready);
  assign o_bf_rd_en   = issue;
  assign o_bf_rd_addr = win_addr;

  assign cfg_bad = (i_cfg_len == '0) || (i_cfg_k == '0) || (i_cfg_stride == '0);

  nn_img_win_agen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .K_WIDTH    (K_WIDTH)
  ) u_agen (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   ((state_q != ST_READ) || i_abort),
    .i_step    (issue),
    .i_len     (len_q),
    .i_k       (k_q),
    .i_stride  (stride_q),
    .o_pending (win_pending),
    .o_last    (win_last),
    .o_addr    (win_addr)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    k_d        = k_q;
    stride_d   = stride_q;
    ld_cnt_d   = ld_cnt_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_last_d  = rd_last_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          len_d    = i_cfg_len;
          k_d      = i_cfg_k;
          stride_d = i_cfg_stride;
          ld_cnt_d = '0;
          if (cfg_bad) done_d  = 1'b1;
          else         state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ld_fire) begin
          if (ld_cnt_q == (len_q - ADDR_WIDTH'(1))) begin
            ld_cnt_d = '0;
            state_d  = ST_READ;
          end else begin
            ld_cnt_d = ld_cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_READ: begin
        if (issue) begin
          rd_valid_d = 1'b1;
          rd_data_d  = i_bf_rd_data;
          rd_last_d  = win_last;
        end else if (i_rd_ready) begin
          rd_valid_d = 1'b0;
        end
        // Covers K > len as well: nothing pending and nothing held.
        if (!win_pending && (!rd_valid_q || i_rd_ready)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides anything decided above, including a same-cycle handshake.
    if (i_abort) begin
      state_d    = ST_IDLE;
      ld_cnt_d   = '0;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      done_d     = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      k_q        <= '0;
      stride_q   <= '0;
      ld_cnt_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      k_q        <= k_d;
      stride_q   <= stride_d;
      ld_cnt_q   <= ld_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_last_q  <= rd_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;
  assign o_rd_last  = rd_last_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_nn_img_bf_ctrl.sv
// Self-checking bench for nn_img_bf_ctrl with a 16-entry behavioural buffer.
module tb_nn_img_bf_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned TW = DW * 6;
  localparam int unsigned KW = 4;

  logic          clk;
  logic          rst_n;
  logic          i_start, i_abort;
  logic [AW-1:0] i_cfg_len;
  logic [KW-1:0] i_cfg_k, i_cfg_stride;
  logic          i_ld_valid;
  logic [TW-1:0] i_ld_data;
  logic          o_ld_ready;
  logic          o_bf_wr_en;
  logic [AW-1:0] o_bf_wr_addr;
  logic [TW-1:0] o_bf_wr_data;
  logic          o_bf_rd_en;
  logic [AW-1:0] o_bf_rd_addr;
  logic [TW-1:0] i_bf_rd_data;
  logic          o_rd_valid;
  logic [TW-1:0] o_rd_data;
  logic          o_rd_last;
  logic          i_rd_ready;
  logic          o_busy, o_done;

  nn_img_bf_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOTAL_DATA_WIDTH(TW), .K_WIDTH(KW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_cfg_len(i_cfg_len), .i_cfg_k(i_cfg_k), .i_cfg_stride(i_cfg_stride),
    .i_ld_valid(i_ld_valid), .i_ld_data(i_ld_data), .o_ld_ready(o_ld_ready),
    .o_bf_wr_en(o_bf_wr_en), .o_bf_wr_addr(o_bf_wr_addr), .o_bf_wr_data(o_bf_wr_data),
    .o_bf_rd_en(o_bf_rd_en), .o_bf_rd_addr(o_bf_rd_addr), .i_bf_rd_data(i_bf_rd_data),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last),
    .i_rd_ready(i_rd_ready), .o_busy(o_busy), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural image buffer.
  logic [TW-1:0] mem [16];
  always @(posedge clk) if (o_bf_wr_en) mem[o_bf_wr_addr[3:0]] <= o_bf_wr_data;
  assign i_bf_rd_data = mem[o_bf_rd_addr[3:0]];

  int n_checks = 0;
  int n_fail   = 0;

  logic [TW-1:0] img [16];
  logic [TW-1:0] exp_data [$];
  logic          exp_last [$];
  logic [TW-1:0] obs_data [$];
  logic          obs_last [$];
  int  done_cnt, done_cyc, stall_err, last_ld_cyc, first_v_cyc, last_v_cyc;
  bit  timed_out;
  logic ab_busy, ab_valid;

  // Reference: every full window in order, word by word.
  task automatic build_exp(input int len, input int k, input int stride);
    exp_data.delete();
    exp_last.delete();
    if (k <= len)
      for (int b = 0; b + k <= len; b += stride)
        for (int j = 0; j < k; j++) begin
          exp_data.push_back(img[b+j]);
          exp_last.push_back(j == k - 1);
        end
  endtask

  // Drives one start..done sequence and records what the consumer saw.
  task automatic run_image(input int len, input int k, input int stride,
                           input int ld_pct, input int rd_pct, input int abort_after);
    int ld_idx = 0;
    int settle = 0;
    int ab_cyc = -1;
    bit prev_stall = 0;
    bit aborted = 0;
    bit fin = 0;
    logic [TW-1:0] prev_data = '0;
    logic prev_last = 1'b0;
    obs_data.delete(); obs_last.delete();
    done_cnt = 0; done_cyc = -1; stall_err = 0; timed_out = 0;
    last_ld_cyc = -1; first_v_cyc = -1; last_v_cyc = -1;
    ab_busy = 1'b1; ab_valid = 1'b1;
    i_cfg_len = AW'(len); i_cfg_k = KW'(k); i_cfg_stride = KW'(stride);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      i_abort = 1'b0;
      if (abort_after >= 0 && !aborted && obs_data.size() == abort_after) begin
        aborted = 1; ab_cyc = cyc;
        i_abort = 1'b1; i_rd_ready = 1'b0; i_ld_valid = 1'b0;
      end else begin
        i_rd_ready = (int'($urandom_range(99)) < rd_pct);
        if (ld_idx < len && int'($urandom_range(99)) < ld_pct) begin
          i_ld_valid = 1'b1; i_ld_data = img[ld_idx];
        end else begin
          i_ld_valid = 1'b0; i_ld_data = TW'({$urandom, $urandom});
        end
      end
      @(negedge clk);
      if (o_ld_ready && i_ld_valid) begin
        ld_idx++; last_ld_cyc = cyc;
      end
      if (o_rd_valid) begin
        if (prev_stall && (o_rd_data !== prev_data || o_rd_last !== prev_last)) stall_err++;
        if (first_v_cyc < 0) first_v_cyc = cyc;
        last_v_cyc = cyc;
        if (i_rd_ready) begin
          obs_data.push_back(o_rd_data);
          obs_last.push_back(o_rd_last);
        end
      end
      prev_stall = o_rd_valid && !i_rd_ready;
      prev_data  = o_rd_data;
      prev_last  = o_rd_last;
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (aborted && cyc == ab_cyc + 1) begin
        ab_busy = o_busy; ab_valid = o_rd_valid;
      end
      if ((done_cnt > 0 || aborted) && !o_busy) begin
        settle++;
        if (settle >= 4) fin = 1;
      end
      @(posedge clk); #1;
    end
    if (!fin) timed_out = 1;
    i_ld_valid = 1'b0; i_rd_ready = 1'b0; i_abort = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({o_rd_valid, o_rd_last, o_busy, o_done, o_ld_ready, o_bf_wr_en, o_bf_rd_en} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {o_rd_valid, o_rd_last, o_busy, o_done, o_ld_ready, o_bf_wr_en, o_bf_rd_en});
    end
    n_checks++;
    if (o_rd_data !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", o_rd_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_cfg;
    for (int v = 0; v < 3; v++) begin
      @(posedge clk); #1;
      i_cfg_len    = (v == 0) ? AW'(0) : AW'(8);
      i_cfg_k      = (v == 1) ? KW'(0) : KW'(3);
      i_cfg_stride = (v == 2) ? KW'(0) : KW'(1);
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({o_done, o_busy, o_ld_ready} !== 3'b100) begin
        n_fail++; $display("FAIL bad_cfg%0d_pulse: got done/busy/rdy %b expected 100", v, {o_done, o_busy, o_ld_ready});
      end
      @(negedge clk);
      n_checks++;
      if ({o_done, o_busy, o_ld_ready} !== 3'b000) begin
        n_fail++; $display("FAIL bad_cfg%0d_after: got done/busy/rdy %b expected 000", v, {o_done, o_busy, o_ld_ready});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stride1;
    for (int i = 0; i < 16; i++) img[i] = TW'(i);
    build_exp(8, 3, 1);
    run_image(8, 3, 1, 100, 100, -1);
    n_checks++;
    if (timed_out || obs_data.size() != 18) begin
      n_fail++; $display("FAIL s1_count: got %0d words (timeout %0d) expected 18", obs_data.size(), timed_out);
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
        n_fail++; $display("FAIL s1_word%0d: got %0h/%b expected %0h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      end
    end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL s1_done: got %0d pulses expected 1", done_cnt); end
    n_checks++;
    if (first_v_cyc - last_ld_cyc != 2) begin
      n_fail++; $display("FAIL s1_latency: got %0d expected 2", first_v_cyc - last_ld_cyc);
    end
    n_checks++;
    if (last_v_cyc - first_v_cyc + 1 != 18) begin
      n_fail++; $display("FAIL s1_throughput: got %0d cycles expected 18", last_v_cyc - first_v_cyc + 1);
    end
  endtask

  task automatic test_stride2;
    for (int i = 0; i < 16; i++) img[i] = TW'(i);
    build_exp(8, 3, 2);
    run_image(8, 3, 2, 100, 100, -1);
    n_checks++;
    if (timed_out || obs_data.size() != 9) begin
      n_fail++; $display("FAIL s2_count: got %0d words (timeout %0d) expected 9", obs_data.size(), timed_out);
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
        n_fail++; $display("FAIL s2_word%0d: got %0h/%b expected %0h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      end
    end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL s2_done: got %0d pulses expected 1", done_cnt); end
  endtask

  task automatic test_k_gt_len;
    for (int i = 0; i < 16; i++) img[i] = TW'(i + 32);
    run_image(4, 5, 1, 100, 100, -1);
    n_checks++;
    if (timed_out || obs_data.size() != 0) begin
      n_fail++; $display("FAIL kgt_count: got %0d words (timeout %0d) expected 0", obs_data.size(), timed_out);
    end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL kgt_done: got %0d pulses expected 1", done_cnt); end
    n_checks++;
    if (done_cyc - last_ld_cyc != 2) begin
      n_fail++; $display("FAIL kgt_done_time: got %0d expected 2", done_cyc - last_ld_cyc);
    end
  endtask

  task automatic test_random_gaps;
    for (int i = 0; i < 16; i++) img[i] = TW'({$urandom, $urandom});
    build_exp(16, 4, 4);
    run_image(16, 4, 4, 60, 50, -1);
    n_checks++;
    if (timed_out || obs_data.size() != 16) begin
      n_fail++; $display("FAIL gaps_count: got %0d words (timeout %0d) expected 16", obs_data.size(), timed_out);
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
        n_fail++; $display("FAIL gaps_word%0d: got %0h/%b expected %0h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      end
    end
    n_checks++;
    if (stall_err != 0) begin n_fail++; $display("FAIL gaps_stall: got %0d changes expected 0", stall_err); end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL gaps_done: got %0d pulses expected 1", done_cnt); end
  endtask

  task automatic test_abort_restart;
    for (int i = 0; i < 16; i++) img[i] = TW'(i);
    build_exp(8, 3, 1);
    run_image(8, 3, 1, 100, 100, 5);
    n_checks++;
    if (timed_out || obs_data.size() != 5) begin
      n_fail++; $display("FAIL abort_count: got %0d words (timeout %0d) expected 5", obs_data.size(), timed_out);
    end
    for (int i = 0; i < 5 && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
        n_fail++; $display("FAIL abort_word%0d: got %0h/%b expected %0h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      end
    end
    n_checks++;
    if ({ab_busy, ab_valid} !== 2'b00) begin
      n_fail++; $display("FAIL abort_state: got busy/valid %b expected 00", {ab_busy, ab_valid});
    end
    n_checks++;
    if (done_cnt != 0) begin n_fail++; $display("FAIL abort_nodone: got %0d pulses expected 0", done_cnt); end
    for (int i = 0; i < 16; i++) img[i] = TW'(i + 100);
    build_exp(6, 2, 2);
    run_image(6, 2, 2, 100, 100, -1);
    n_checks++;
    if (timed_out || obs_data.size() != 6) begin
      n_fail++; $display("FAIL restart_count: got %0d words (timeout %0d) expected 6", obs_data.size(), timed_out);
    end
    for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
        n_fail++; $display("FAIL restart_word%0d: got %0h/%b expected %0h/%b", i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
      end
    end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL restart_done: got %0d pulses expected 1", done_cnt); end
  endtask

  task automatic test_random_cfgs;
    for (int t = 0; t < 4; t++) begin
      int len, k, stride;
      len    = int'($urandom_range(16, 1));
      k      = int'($urandom_range(8, 1));
      stride = int'($urandom_range(5, 1));
      for (int i = 0; i < 16; i++) img[i] = TW'({$urandom, $urandom});
      build_exp(len, k, stride);
      run_image(len, k, stride, 70, 60, -1);
      n_checks++;
      if (timed_out || obs_data.size() != exp_data.size()) begin
        n_fail++; $display("FAIL rnd%0d_count: got %0d words (timeout %0d) expected %0d", t, obs_data.size(), timed_out, exp_data.size());
      end
      for (int i = 0; i < exp_data.size() && i < obs_data.size(); i++) begin
        n_checks++;
        if (obs_data[i] !== exp_data[i] || obs_last[i] !== exp_last[i]) begin
          n_fail++; $display("FAIL rnd%0d_word%0d: got %0h/%b expected %0h/%b", t, i, obs_data[i], obs_last[i], exp_data[i], exp_last[i]);
        end
      end
      n_checks++;
      if (stall_err != 0 || done_cnt != 1) begin
        n_fail++; $display("FAIL rnd%0d_status: got stall %0d done %0d expected 0/1", t, stall_err, done_cnt);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0; i_abort = 1'b0;
    i_cfg_len = '0; i_cfg_k = '0; i_cfg_stride = '0;
    i_ld_valid = 1'b0; i_ld_data = '0; i_rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_bad_cfg();
    test_stride1();
    test_stride2();
    test_k_gt_len();
    test_random_gaps();
    test_abort_restart();
    test_random_cfgs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
